// File: rtl/accum_adder_if.sv
// Stream handshake bundle for accum_adder: operand input, result output,
// start/bias control and busy status.
interface accum_adder_if #(
    parameter int DWIDTH = 16
);
    logic              start;
    logic [DWIDTH-1:0] bias;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_sat;
    logic              busy;

    modport master (
        output start, bias, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, bias, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/accum_adder.sv
// Accumulates LEN signed operands onto a preloaded bias in a wide accumulator
// and returns one DWIDTH-bit result, clamped or wrapped, with an overflow flag.
module accum_adder #(
    parameter int DWIDTH = 16,
    parameter int LEN    = 64,
    parameter int SAT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    accum_adder_if.slave bus
);
    localparam int CNTW = $clog2(LEN + 1);
    localparam int ACCW = DWIDTH + CNTW;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                 state, state_nx;
    logic signed [ACCW-1:0] acc, sum, bias_x, data_x;
    logic [CNTW-1:0]        cnt;
    logic [DWIDTH-1:0]      res_q, res_nx;
    logic                   sat_q, ovf;
    logic                   load, beat, last;
    logic                   in_rdy, o_vld, bsy;

    assign bias_x = {{(ACCW-DWIDTH){bus.bias[DWIDTH-1]}}, bus.bias};
    assign data_x = {{(ACCW-DWIDTH){bus.in_data[DWIDTH-1]}}, bus.in_data};
    assign sum    = acc + data_x;

    // Sum fits in DWIDTH only if every bit from DWIDTH-1 upward is a sign copy.
    assign ovf = !((&sum[ACCW-1:DWIDTH-1]) || !(|sum[ACCW-1:DWIDTH-1]));

    always_comb begin
        res_nx = sum[DWIDTH-1:0];
        if (SAT != 0 && ovf)
            res_nx = sum[ACCW-1] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                 : {1'b0, {(DWIDTH-1){1'b1}}};
    end

    assign load = bus.start && (state == IDLE || (state == DONE && bus.out_ready));
    assign beat = (state == ACC) && bus.in_valid;
    assign last = beat && (cnt == CNTW'(LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ACC;
            ACC:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = bus.start ? ACC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_rdy = 1'b0;
        o_vld  = 1'b0;
        bsy    = 1'b0;
        case (state)
            ACC:  begin in_rdy = 1'b1; bsy = 1'b1; end
            DONE: begin o_vld  = 1'b1; bsy = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
            sat_q <= 1'b0;
        end else if (load) begin
            acc <= bias_x;
            cnt <= '0;
        end else if (beat) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (last) begin
                res_q <= res_nx;
                sat_q <= ovf;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = o_vld;
    assign bus.busy      = bsy;
    assign bus.out_data  = res_q;
    assign bus.out_sat   = sat_q;
endmodule

// File: doc/accum_adder.md
Name: accum_adder

Overview:
- Parameterised sequential successor to the two-operand combinational adder.
- Accumulates a stream of LEN signed DWIDTH-bit operands onto a preloaded bias, using a wide internal accumulator.
- Returns one DWIDTH-bit result with optional saturation and an overflow flag.
- Sits between the MAC/multiplier stage and the sigmoid block in each neuron layer; ready/valid handshakes on both sides.

Parameters:
- DWIDTH, 16: operand, bias and result width (signed two's complement).
- LEN, 64: operands accumulated per operation; legal range 1 to 1024.
- SAT, 1: 1 = clamp result to DWIDTH range; 0 = wrap (keep low DWIDTH bits, same as plain + truncation).

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin an operation; sampled only when idle, or in DONE together with an out handshake.
- bias, input, DWIDTH: signed initial accumulator value; sampled with accepted start.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: block accepts an operand this cycle.
- in_data, input, DWIDTH: signed operand.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out_data, output, DWIDTH: result.
- out_sat, output, 1: true sum was outside DWIDTH signed range; valid with out_valid.
- busy, output, 1: high in ACC and DONE.

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0.
  - Internal accumulator and beat counter clear to 0.
  - Reset in any state, including mid-accumulation or with a result pending, discards the operation; no output is produced.
- Internal accumulator width: ACCW = DWIDTH + clog2(LEN+1). Every operand and the bias are sign-extended to ACCW, so no intermediate overflow occurs.
  - A transient excursion past DWIDTH range that returns in range does not set out_sat.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> acc <= sext(bias), cnt <= 0, go to ACC.
- State ACC:
  - in_ready=1 combinationally; busy=1; start is ignored.
  - A beat is in_valid && in_ready. Each beat: acc <= acc + sext(in_data), cnt <= cnt+1.
  - Cycles with in_valid=0 hold acc and cnt.
  - Beat with cnt==LEN-1 is the last one; the final sum S = acc + sext(in_data) is resolved into the output registers that same edge, then go to DONE.
  - Latency: last beat accepted on edge t -> out_valid=1 on the cycle after t.
- Result rule:
  - out_sat = (S > 2^(DWIDTH-1)-1) || (S < -2^(DWIDTH-1)).
  - SAT=1: out_data = clamp(S) to 0x7FFF/0x8000 (for DWIDTH=16).
  - SAT=0: out_data = S[DWIDTH-1:0].
- State DONE:
  - out_valid=1, in_ready=0; out_data and out_sat held stable until the handshake.
  - out_valid && out_ready:
    - start=0 -> IDLE; out_valid low the next cycle.
    - start=1 in the same cycle -> reload acc from bias, cnt <= 0, go directly to ACC (back-to-back, no idle cycle).
  - start without out_ready in DONE is ignored.
- LEN=1: the first beat is also the last; S = bias + operand.
- out_data is not cleared on handshake; it is meaningful only while out_valid=1.

Test Plan:
1. DWIDTH=16, LEN=4, SAT=1, bias=0, operands 1,2,3,4 on consecutive cycles -> out_valid one cycle after 4th beat; out_data=10, out_sat=0; in_ready=0 while out_valid=1.
2. Positive overflow: bias=0x7000, operands 0x4000 x4 (S=0x17000) -> SAT=1: out_data=0x7FFF, out_sat=1; SAT=0 build: out_data=0x7000, out_sat=1.
3. Negative overflow, then transient: bias=0x8000, operands 0xFFFF x4 -> out_data=0x8000, out_sat=1. Next op bias=0x7FFF, operands 0x7FFF, 0x8001, 0x0000, 0x0000 -> out_data=0x7FFF, out_sat=0.
4. Flow control: in_valid gaps of 1-3 cycles and out_ready low 5 cycles -> sum still 10; out_data/out_valid stable while stalled; start pulses during ACC and stalled DONE ignored. Then out_ready=1 with start=1, bias=5 -> ACC next cycle, no IDLE cycle; operands 1,1,1,1 -> out_data=9.
5. Reset mid-op: assert rst after 2 of 4 beats -> next cycle all outputs 0, IDLE. New op bias=0, operands 1,2,3,4 -> 10 (no residue).
6. LEN=1 instance: bias=-3, operand 0x0007 -> out_data=4, out_valid one cycle after the beat.
